// File: rtl/uart_msg_arbiter.sv
// uart_msg_arbiter: round-robin arbiter sharing one uart_tx between NREQ message sources
// Latches the winner's message and feeds its bytes MSB first through the tstart/tready handshake.
module uart_msg_arbiter #(
  parameter int NREQ   = 2,
  parameter int NBYTES = 4,
  parameter int LENW   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*NBYTES*8-1:0]   msg,
  input  logic [NREQ*LENW-1:0]       len,
  output logic [NREQ-1:0]            grant,
  output logic [2:0]                 grant_id,
  output logic                       busy,
  output logic                       done,
  output logic                       tstart,
  output logic [7:0]                 tbus,
  input  logic                       tready
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, FIN} state_t;
  state_t              r_state;
  logic [2:0]          r_ptr;
  logic [NBYTES*8-1:0] r_msg;
  logic [LENW-1:0]     r_rem;
  logic [2*NREQ-1:0]   w_dbl;
  logic [NREQ-1:0]     w_rot;
  logic [3:0]          w_sum;
  logic [2:0]          w_win;
  logic                w_any;
  logic [LENW-1:0]     w_raw;
  logic [LENW-1:0]     w_len;
  // w_rot bit j stands for requester (ptr+1+j) mod NREQ, so the lowest set bit wins
  assign w_dbl = {req, req};
  assign w_rot = NREQ'(w_dbl >> (32'(r_ptr) + 1));
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_sum = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_any = 1'b1;
        w_sum = 4'(32'(r_ptr) + 1 + j);
        w_win = (w_sum >= 4'(NREQ)) ? 3'(w_sum - 4'(NREQ)) : 3'(w_sum);
      end
    end
    w_raw = len[w_win*LENW +: LENW];
    w_len = (w_raw > LENW'(NBYTES)) ? LENW'(NBYTES) : w_raw;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= 3'(NREQ - 1);
      r_msg    <= '0;
      r_rem    <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tstart   <= 1'b0;
      tbus     <= '0;
    end else begin
      grant  <= '0;
      tstart <= 1'b0;
      done   <= 1'b0;
      case (r_state)
        IDLE: begin
          busy <= w_any && tready;
          if (w_any && tready) begin
            grant    <= NREQ'(1) << w_win;
            grant_id <= w_win;
            r_ptr    <= w_win;
            r_msg    <= msg[w_win*NBYTES*8 +: NBYTES*8];
            r_rem    <= w_len;
            r_state  <= (w_len != '0) ? SEND : FIN;
          end
        end
        SEND: if (tready) begin
          tstart  <= 1'b1;
          tbus    <= r_msg[NBYTES*8-1 -: 8];
          r_msg   <= r_msg << 8;
          r_rem   <= r_rem - LENW'(1);
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (!tready) r_state <= WAIT_DONE;
        WAIT_DONE: if (tready) r_state <= (r_rem != '0) ? SEND : FIN;
        FIN: begin
          done    <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_msg_arbiter.sv
// tb_uart_msg_arbiter: directed checks of arbitration, byte sequencing, reset and tready gating
module tb_uart_msg_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [63:0] msg = '0;
  logic [5:0]  len = '0;
  logic [1:0]  grant;
  logic [2:0]  grant_id;
  logic        busy, done, tstart;
  logic [7:0]  tbus;
  logic        tready = 1'b1;
  int total = 0, bad = 0, cyc = 0, n_done = 0, n_start = 0, g_cyc = 0, d_cyc = 0, hold = 3;
  int s0, dn0, g0;
  bit model_en = 1'b1;
  logic [7:0] bq[$];
  logic [1:0] gq[$];

  always #5 clk = ~clk;

  uart_msg_arbiter #(.NREQ(2), .NBYTES(4), .LENW(3)) dut (
    .clk(clk), .rst(rst), .req(req), .msg(msg), .len(len),
    .grant(grant), .grant_id(grant_id), .busy(busy), .done(done),
    .tstart(tstart), .tbus(tbus), .tready(tready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input logic [63:0] exp, input int n);
    check({tag, "_count"}, bq.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), (bq.size() > i) ? {24'h0, bq[i]} : 32'hffff_ffff, {24'h0, exp[63-8*i -: 8]});
  endtask

  task automatic wait_grant(input string tag);
    int i = 0;
    do begin @(negedge clk); i++; end while (grant == '0 && i < 200);
    check({tag, "_grant_seen"}, grant != '0, 1);
  endtask

  task automatic wait_done(input string tag);
    int i = 0;
    int d = n_done;
    do begin @(negedge clk); i++; end while (n_done == d && i < 600);
    check({tag, "_done_seen"}, n_done != d, 1);
  endtask

  task automatic reset_dut();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    bq.delete();
    gq.delete();
  endtask

  // event monitor, sampled 1 time unit after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (grant != '0) begin
      gq.push_back(grant);
      g_cyc = cyc;
      check("grant_onehot", $onehot(grant), 1);
      check("grant_vs_tstart", tstart, 0);
      check("grant_busy", busy, 1);
    end
    if (tstart) begin
      bq.push_back(tbus);
      n_start++;
      check("tstart_tready", tready, 1);
    end
    if (done) begin
      n_done++;
      d_cyc = cyc;
    end
  end

  // uart_tx model: goes busy one cycle after tstart, idle again after hold cycles
  initial forever begin
    @(negedge clk);
    if (tstart && model_en) begin
      @(negedge clk) tready = 1'b0;
      repeat (hold) @(negedge clk);
      tready = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tstart", tstart, 0);
    check("rst_tbus", tbus, 0);
    rst = 1'b0;

    // single 4-byte message with a slow transmitter
    hold = 20;
    msg[31:0] = 32'h4142_4344;
    len[2:0] = 3'd4;
    req = 2'b01;
    wait_grant("t1");
    check("t1_grant", grant, 2'b01);
    check("t1_grant_id", grant_id, 0);
    req = 2'b00;
    wait_done("t1");
    check("t1_done_busy", busy, 1);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_busy_after", busy, 0);
    check("t1_starts", n_start, 4);
    check_bytes("t1", 64'h4142_4344_0000_0000, 4);

    // fairness with both requesters re-raising after each grant
    reset_dut();
    hold = 2;
    msg = 64'hB0B1_B2B3_A0A1_A2A3;
    len = {3'd1, 3'd1};
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_grant("t2");
      req = req & ~grant;
      @(negedge clk) req = 2'b11;
      wait_done("t2");
    end
    req = 2'b00;
    check("t2_g0", gq[0], 2'b01);
    check("t2_g1", gq[1], 2'b10);
    check("t2_g2", gq[2], 2'b01);
    check("t2_g3", gq[3], 2'b10);
    check_bytes("t2", 64'hA0B0_A0B0_0000_0000, 4);

    // short, zero and over-long lengths
    bq.delete();
    msg[31:0] = 32'h3132_5555;
    len[2:0] = 3'd2;
    req = 2'b01;
    wait_grant("t3a");
    req = 2'b00;
    wait_done("t3a");
    check_bytes("t3a", 64'h3132_0000_0000_0000, 2);
    bq.delete();
    s0 = n_start;
    len[2:0] = 3'd0;
    req = 2'b01;
    wait_grant("t3b");
    check("t3b_grant", grant, 2'b01);
    req = 2'b00;
    wait_done("t3b");
    check("t3b_done_after_grant", d_cyc - g_cyc, 1);
    check("t3b_no_tstart", n_start - s0, 0);
    bq.delete();
    msg[31:0] = 32'h1122_3344;
    len[2:0] = 3'd7;
    req = 2'b01;
    wait_grant("t3c");
    req = 2'b00;
    wait_done("t3c");
    check_bytes("t3c", 64'h1122_3344_0000_0000, 4);

    // requester 1 raised during message 0, slot 0 altered after its grant
    reset_dut();
    hold = 3;
    s0 = n_start;
    msg = 64'h6100_0000_5152_5354;
    len = {3'd1, 3'd4};
    req = 2'b01;
    wait_grant("t4");
    req = 2'b00;
    msg[31:0] = 32'hDEAD_BEEF;
    for (int i = 0; i < 200 && n_start < s0 + 2; i++) @(negedge clk);
    check("t4_second_byte", n_start - s0, 2);
    req[1] = 1'b1;
    wait_done("t4");
    @(negedge clk);
    check("t4_pending_grant", grant, 2'b10);
    check("t4_grant_gap", g_cyc - d_cyc, 1);
    req = 2'b00;
    wait_done("t4b");
    check_bytes("t4", 64'h5152_5354_6100_0000, 5);

    // asynchronous reset while waiting on byte 2
    reset_dut();
    hold = 10;
    s0 = n_start;
    msg[31:0] = 32'h7172_7374;
    len[2:0] = 3'd4;
    req = 2'b01;
    wait_grant("t5");
    req = 2'b00;
    for (int i = 0; i < 200 && n_start < s0 + 2; i++) @(negedge clk);
    for (int i = 0; i < 20 && tready; i++) @(negedge clk);
    @(negedge clk);
    check("t5_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_tstart", tstart, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_grant", grant, 0);
    dn0 = n_done;
    bq.delete();
    req = 2'b11;
    msg[63:32] = 32'h8100_0000;
    len[5:3] = 3'd1;
    @(negedge clk) rst = 1'b0;
    wait_grant("t5");
    check("t5_first_winner", grant, 2'b01);
    req = 2'b00;
    wait_done("t5");
    check("t5_single_done", n_done - dn0, 1);
    check_bytes("t5", 64'h7172_7374_0000_0000, 4);

    // tready low blocks arbitration
    bq.delete();
    model_en = 1'b0;
    tready = 1'b0;
    msg[31:0] = 32'h8800_0000;
    len[2:0] = 3'd1;
    g0 = gq.size();
    s0 = n_start;
    req = 2'b01;
    repeat (6) @(negedge clk);
    check("t6_no_grant", gq.size() - g0, 0);
    check("t6_no_tstart", n_start - s0, 0);
    tready = 1'b1;
    @(negedge clk);
    check("t6_grant_on_ready", grant, 2'b01);
    req = 2'b00;
    model_en = 1'b1;
    wait_done("t6");
    check_bytes("t6", 64'h8800_0000_0000_0000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
